// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic I2C_READ = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line with registered rise/fall pulses.
// o_level is delayed to line up with the pulses so callers can qualify edges with it.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // Idle I2C lines are high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, write bytes to rx_data, read bytes from tx_data.
// No clock stretching; SDA is only ever pulled low through sda_oe.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy
);

  logic w_sclLevel, w_sclRise, w_sclFall;
  logic w_sdaLevel, w_sdaRise, w_sdaFall;
  logic w_start, w_stop;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclSync (
    .clk(clk), .rst(rst), .i_in(scl_i),
    .o_level(w_sclLevel), .o_rise(w_sclRise), .o_fall(w_sclFall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdaSync (
    .clk(clk), .rst(rst), .i_in(sda_i),
    .o_level(w_sdaLevel), .o_rise(w_sdaRise), .o_fall(w_sdaFall)
  );

  assign w_start = w_sdaFall & w_sclLevel;
  assign w_stop  = w_sdaRise & w_sclLevel;

  i2c_tgt_state_e r_state, w_stateNext;
  logic [2:0] r_bitCnt, w_bitCntNext;
  logic       r_byteDone, w_byteDoneNext;
  logic [7:0] r_shift, w_shiftNext;
  logic       r_rw, w_rwNext;
  logic       r_ackBit, w_ackBitNext;
  logic       r_sdaOe, w_sdaOeNext;
  logic [7:0] r_rxData, w_rxDataNext;
  logic       r_rxValid, w_rxValidNext;
  logic       r_txAck, w_txAckNext;
  logic       r_busy, w_busyNext;
  logic       w_loadTx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bitCnt   <= 3'd0;
      r_byteDone <= 1'b0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_ackBit   <= I2C_NACK;
      r_sdaOe    <= 1'b0;
      r_rxData   <= 8'h00;
      r_rxValid  <= 1'b0;
      r_txAck    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_bitCnt   <= w_bitCntNext;
      r_byteDone <= w_byteDoneNext;
      r_shift    <= w_shiftNext;
      r_rw       <= w_rwNext;
      r_ackBit   <= w_ackBitNext;
      r_sdaOe    <= w_sdaOeNext;
      r_rxData   <= w_rxDataNext;
      r_rxValid  <= w_rxValidNext;
      r_txAck    <= w_txAckNext;
      r_busy     <= w_busyNext;
    end
  end

  // The first SCL fall after START carries no data, so byte completion is flagged
  // on the 8th rise and acted on at the following fall.
  always_comb begin
    w_stateNext    = r_state;
    w_bitCntNext   = r_bitCnt;
    w_byteDoneNext = r_byteDone;
    w_shiftNext    = r_shift;
    w_rwNext       = r_rw;
    w_ackBitNext   = r_ackBit;
    w_sdaOeNext    = r_sdaOe;
    w_rxDataNext   = r_rxData;
    w_rxValidNext  = 1'b0;
    w_txAckNext    = 1'b0;
    w_busyNext     = r_busy;
    w_loadTx       = 1'b0;

    if (w_stop) begin
      w_stateNext    = ST_IDLE;
      w_bitCntNext   = 3'd0;
      w_byteDoneNext = 1'b0;
      w_sdaOeNext    = 1'b0;
      w_busyNext     = 1'b0;
    end else if (w_start) begin
      w_stateNext    = ST_ADDR;
      w_bitCntNext   = 3'd0;
      w_byteDoneNext = 1'b0;
      w_sdaOeNext    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_WR_DATA: begin
          if (w_sclRise) begin
            w_shiftNext = {r_shift[6:0], w_sdaLevel};
            if (r_bitCnt == 3'd7) begin
              w_bitCntNext   = 3'd0;
              w_byteDoneNext = 1'b1;
            end else begin
              w_bitCntNext = r_bitCnt + 3'd1;
            end
          end else if (w_sclFall && r_byteDone) begin
            w_byteDoneNext = 1'b0;
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == ADDR) begin
                w_stateNext = ST_ADDR_ACK;
                w_sdaOeNext = 1'b1;
                w_rwNext    = r_shift[0];
                w_busyNext  = 1'b1;
              end else begin
                w_stateNext = ST_IDLE;
                w_busyNext  = 1'b0;
              end
            end else begin
              w_rxDataNext  = r_shift;
              w_rxValidNext = 1'b1;
              w_sdaOeNext   = 1'b1;
              w_stateNext   = ST_WR_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_sclFall) begin
            if (r_rw == I2C_READ) begin
              w_loadTx = 1'b1;
            end else begin
              w_sdaOeNext = 1'b0;
              w_stateNext = ST_WR_DATA;
            end
          end
        end
        ST_WR_ACK: begin
          if (w_sclFall) begin
            w_sdaOeNext = 1'b0;
            w_stateNext = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (w_sclFall) begin
            if (r_bitCnt == 3'd7) begin
              w_bitCntNext = 3'd0;
              w_sdaOeNext  = 1'b0;
              w_stateNext  = ST_RD_ACK;
            end else begin
              w_bitCntNext = r_bitCnt + 3'd1;
              w_shiftNext  = {r_shift[6:0], 1'b0};
              w_sdaOeNext  = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_sclRise) begin
            w_ackBitNext = w_sdaLevel;
          end else if (w_sclFall) begin
            if (r_ackBit == I2C_ACK) begin
              w_loadTx = 1'b1;
            end else begin
              w_stateNext = ST_IDLE;
              w_sdaOeNext = 1'b0;
              w_busyNext  = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase

      if (w_loadTx) begin
        w_shiftNext  = tx_data;
        w_txAckNext  = 1'b1;
        w_sdaOeNext  = ~tx_data[7];
        w_bitCntNext = 3'd0;
        w_stateNext  = ST_RD_DATA;
      end
    end
  end

  assign sda_oe   = r_sdaOe;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign tx_ack   = r_txAck;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: a bit-banged controller plus a scoreboard
// monitor that matches rx_valid/tx_ack pulses against expected bytes.
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h50;
  localparam int         Q   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclC = 1'b1;
  logic       sdaC = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sdaLine;
  logic       sda_oe, rx_valid, tx_ack, busy;
  logic [7:0] rx_data;

  assign sdaLine = sdaC & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(sclC), .sda_i(sdaLine), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_ack(tx_ack), .busy(busy)
  );

  int passCount  = 0;
  int checkCount = 0;
  logic [7:0] rxExpQ[$];
  logic [7:0] txExpQ[$];
  logic [7:0] rxModel = 8'h00;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Scoreboard monitor: every output pulse must match a queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rxExpQ.size() == 0) checkOutput("rxValidUnexpected", 8'h01, 8'h00);
        else checkOutput("rxData", rx_data, rxExpQ.pop_front());
      end
      if (tx_ack) begin
        if (txExpQ.size() == 0) checkOutput("txAckUnexpected", 8'h01, 8'h00);
        else checkOutput("txAckByte", tx_data, txExpQ.pop_front());
      end
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clockBit(input logic b, output logic seen);
    sdaC = b;
    waitClk(Q);
    sclC = 1'b1;
    waitClk(Q);
    seen = sdaLine;
    waitClk(Q);
    sclC = 1'b0;
    waitClk(Q);
  endtask

  task automatic busStart(input bit repeated);
    if (repeated) begin
      sdaC = 1'b1;
      waitClk(Q);
      sclC = 1'b1;
      waitClk(Q);
    end else begin
      sdaC = 1'b1;
      sclC = 1'b1;
      waitClk(Q);
    end
    sdaC = 1'b0;
    waitClk(Q);
    sclC = 1'b0;
    waitClk(Q);
  endtask

  task automatic busStop();
    sdaC = 1'b0;
    waitClk(Q);
    sclC = 1'b1;
    waitClk(Q);
    sdaC = 1'b1;
    waitClk(2 * Q);
  endtask

  task automatic addrPhase(input logic [6:0] a, input logic rw, output logic ack);
    logic dummy;
    for (int i = 6; i >= 0; i--) clockBit(a[i], dummy);
    clockBit(rw, dummy);
    clockBit(1'b1, ack);
  endtask

  // Reference behaviour: a matching address ACKs every byte; anything else sees NACKs only.
  task automatic writeXfer(input logic [6:0] a, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input bit repeated, input bit doStop);
    logic [7:0] d[3];
    logic ack, dummy;
    bit match;
    d[0] = b0; d[1] = b1; d[2] = b2;
    match = (a == TGT);
    busStart(repeated);
    addrPhase(a, 1'b0, ack);
    checkOutput("addrAckWr", 8'(ack), match ? 8'h00 : 8'h01);
    checkOutput("busyAfterAddr", 8'(busy), match ? 8'h01 : 8'h00);
    for (int k = 0; k < n; k++) begin
      if (match) begin
        rxExpQ.push_back(d[k]);
        rxModel = d[k];
      end
      for (int i = 7; i >= 0; i--) clockBit(d[k][i], dummy);
      clockBit(1'b1, ack);
      checkOutput("dataAck", 8'(ack), match ? 8'h00 : 8'h01);
    end
    if (doStop) begin
      busStop();
      checkOutput("busyAfterStop", 8'(busy), 8'h00);
      checkOutput("rxHold", rx_data, rxModel);
    end
  endtask

  task automatic readXfer(input logic [6:0] a, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input bit repeated);
    logic [7:0] d[3];
    logic [7:0] got;
    logic ack, dummy;
    bit match;
    d[0] = b0; d[1] = b1; d[2] = b2;
    match = (a == TGT);
    tx_data = d[0];
    if (match) txExpQ.push_back(d[0]);
    busStart(repeated);
    addrPhase(a, 1'b1, ack);
    checkOutput("addrAckRd", 8'(ack), match ? 8'h00 : 8'h01);
    if (match) begin
      for (int k = 0; k < n; k++) begin
        for (int i = 7; i >= 0; i--) begin
          clockBit(1'b1, dummy);
          got[i] = dummy;
        end
        checkOutput("readByte", got, d[k]);
        if (k < n - 1) begin
          tx_data = d[k+1];
          txExpQ.push_back(d[k+1]);
          clockBit(1'b0, dummy);
        end else begin
          clockBit(1'b1, dummy);
        end
      end
      checkOutput("oeAfterNack", 8'(sda_oe), 8'h00);
      checkOutput("busyAfterNack", 8'(busy), 8'h00);
    end
    busStop();
    checkOutput("busyIdleRd", 8'(busy), 8'h00);
  endtask

  task automatic idleAfterReset();
    sclC = 1'b1;
    sdaC = 1'b1;
    waitClk(4);
    rst = 1'b1;
    waitClk(4);
  endtask

  task automatic applyStimulus(input int iterations);
    logic [6:0] a;
    int n;
    for (int it = 0; it < iterations; it++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TGT;
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1)
        readXfer(a, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      else
        writeXfer(a, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic ack, dummy;
    rst = 1'b0;
    waitClk(5);
    checkOutput("rstSdaOe", 8'(sda_oe), 8'h00);
    checkOutput("rstRxData", rx_data, 8'h00);
    checkOutput("rstRxValid", 8'(rx_valid), 8'h00);
    checkOutput("rstTxAck", 8'(tx_ack), 8'h00);
    checkOutput("rstBusy", 8'(busy), 8'h00);
    rst = 1'b1;
    waitClk(5);

    writeXfer(TGT, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b1);
    writeXfer(7'h51, 1, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b1);
    readXfer(TGT, 1, 8'h3C, 8'h00, 8'h00, 1'b0);
    readXfer(TGT, 2, 8'h11, 8'h22, 8'h00, 1'b0);

    writeXfer(TGT, 1, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0);
    readXfer(TGT, 1, 8'hF0, 8'h00, 8'h00, 1'b1);
    checkOutput("rxAfterRepStart", rx_data, 8'h0F);

    // Reset after four data bits of a write: the partial byte must vanish.
    busStart(1'b0);
    addrPhase(TGT, 1'b0, ack);
    checkOutput("addrAckPartial", 8'(ack), 8'h00);
    for (int i = 0; i < 4; i++) clockBit(1'b1, dummy);
    rst = 1'b0;
    rxModel = 8'h00;
    #1;
    checkOutput("oeResetMidWrite", 8'(sda_oe), 8'h00);
    waitClk(2);
    checkOutput("rxAfterReset", rx_data, 8'h00);
    checkOutput("busyAfterReset", 8'(busy), 8'h00);
    idleAfterReset();

    // Reset while the address ACK is being driven: release must not wait for a clock.
    busStart(1'b0);
    for (int i = 6; i >= 0; i--) clockBit(TGT[i], dummy);
    clockBit(1'b0, dummy);
    sdaC = 1'b1;
    waitClk(Q);
    checkOutput("ackDriven", 8'(sda_oe), 8'h01);
    rst = 1'b0;
    #1;
    checkOutput("oeAsyncRelease", 8'(sda_oe), 8'h00);
    idleAfterReset();

    writeXfer(TGT, 1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1);

    applyStimulus(10);

    waitClk(10);
    checkOutput("rxQueueDrained", 8'(rxExpQ.size()), 8'h00);
    checkOutput("txQueueDrained", 8'(txExpQ.size()), 8'h00);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
